// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame buffer and its bit engine.
package spi_pkg;

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE, PENDING} spi_buf_state_t;

    localparam int SPI_BITS       = 8;
    localparam int ST_OVERRUN_BIT = 7;
    localparam int ST_OVF_BIT     = 6;
    localparam int ST_CNT_MSB     = 3;
    localparam int ST_CNT_LSB     = 0;

    // Status byte reported as the first byte of a frame; the count field saturates at 15.
    function automatic logic [7:0] status_byte(input logic ovr, input logic ovf,
                                               input int unsigned cnt);
        logic [7:0] s;
        s = '0;
        s[ST_OVERRUN_BIT]         = ovr;
        s[ST_OVF_BIT]             = ovf;
        s[ST_CNT_MSB:ST_CNT_LSB]  = (cnt > 15) ? 4'hF : 4'(cnt);
        return s;
    endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// Oversampled SPI mode-0 pin front end: synchronisers, edge pulses, rx/tx shifters.
module spi_bit_engine
    import spi_pkg::*;
#(
    parameter int SYNC_FF = 2
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_spi_sclk,
    input  logic                i_spi_cs_n,
    input  logic                i_spi_rx,
    input  logic                i_load,
    input  logic [SPI_BITS-1:0] i_load_data,
    output logic                o_spi_tx,
    output logic                o_byte_done,
    output logic [SPI_BITS-1:0] o_rx_byte,
    output logic                o_cs_rise,
    output logic                o_cs_fall,
    output logic                o_load_req,
    output logic                o_cs_n_s
);

    localparam int BCW = $clog2(SPI_BITS);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(SPI_BITS - 1);

    logic [SYNC_FF-1:0]  r_sclk_sync, r_cs_sync, r_rx_sync;
    logic                r_sclk_d, r_cs_d, r_rx_d;
    logic                r_sclk_rise, r_sclk_fall, r_cs_rise, r_cs_fall;
    logic [BCW-1:0]      r_bit_cnt;
    logic [SPI_BITS-2:0] r_rx_sh;
    logic [SPI_BITS-1:0] r_tx_sh;
    logic                r_wrap;

    // cs sync resets low so a frame already in progress at reset is not mistaken for idle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_rx_sync   <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b0;
            r_rx_d      <= 1'b0;
            r_sclk_rise <= 1'b0;
            r_sclk_fall <= 1'b0;
            r_cs_rise   <= 1'b0;
            r_cs_fall   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_FF-2:0], i_spi_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_FF-2:0], i_spi_cs_n};
            r_rx_sync   <= {r_rx_sync[SYNC_FF-2:0], i_spi_rx};
            r_sclk_d    <= r_sclk_sync[SYNC_FF-1];
            r_cs_d      <= r_cs_sync[SYNC_FF-1];
            r_rx_d      <= r_rx_sync[SYNC_FF-1];
            r_sclk_rise <= r_sclk_sync[SYNC_FF-1] & ~r_sclk_d;
            r_sclk_fall <= ~r_sclk_sync[SYNC_FF-1] & r_sclk_d;
            r_cs_rise   <= r_cs_sync[SYNC_FF-1] & ~r_cs_d;
            r_cs_fall   <= ~r_cs_sync[SYNC_FF-1] & r_cs_d;
        end
    end

    // The fall right after a completed byte loads the next tx byte instead of shifting.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bit_cnt <= '0;
            r_rx_sh   <= '0;
            r_tx_sh   <= '0;
            r_wrap    <= 1'b0;
        end else begin
            if (r_cs_d) begin
                r_bit_cnt <= '0;
                r_wrap    <= 1'b0;
            end else if (r_sclk_rise) begin
                r_rx_sh   <= {r_rx_sh[SPI_BITS-3:0], r_rx_d};
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_wrap    <= (r_bit_cnt == LAST_BIT);
            end else if (r_sclk_fall) begin
                r_wrap    <= 1'b0;
            end

            if (r_cs_rise)
                r_tx_sh <= '0;
            else if (i_load)
                r_tx_sh <= i_load_data;
            else if (r_sclk_fall && !r_cs_d && !r_wrap)
                r_tx_sh <= {r_tx_sh[SPI_BITS-2:0], 1'b0};
        end
    end

    assign o_byte_done = r_sclk_rise & ~r_cs_d & (r_bit_cnt == LAST_BIT);
    assign o_rx_byte   = {r_rx_sh, r_rx_d};
    assign o_load_req  = r_sclk_fall & ~r_cs_d & r_wrap;
    assign o_cs_rise   = r_cs_rise;
    assign o_cs_fall   = r_cs_fall;
    assign o_cs_n_s    = r_cs_d;
    assign o_spi_tx    = ~r_cs_d & r_tx_sh[SPI_BITS-1];

endmodule

// File: rtl/spi_frame_buffer.sv
// SPI receive frame buffer with valid/ack hand-off and response shifter.
// Define SPI_BUF_STATUS_EN to send a status byte as the first byte of every frame.
module spi_frame_buffer
    import spi_pkg::*;
#(
    parameter  int DEPTH   = 4,
    parameter  int SYNC_FF = 2,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                 i_sys_clk,
    input  logic                 i_reset,
    input  logic                 i_spi_sclk,
    input  logic                 i_spi_cs_n,
    input  logic                 i_spi_rx,
    output logic                 o_spi_tx,
    input  logic [7:0]           i_tx_byte,
    output logic                 o_tx_req,
    output logic [DEPTH*8-1:0]   o_rx_data,
    output logic [CW-1:0]        o_rx_count,
    output logic                 o_frame_valid,
    input  logic                 i_frame_ack,
    output logic                 o_overflow,
    output logic                 o_overrun
);

`ifdef SPI_BUF_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    spi_buf_state_t        r_state, w_next;
    logic                  w_byte_done, w_cs_rise, w_cs_fall, w_load_req, w_cs_n_s;
    logic [7:0]            w_rx_byte, w_load_data;
    logic                  w_load, w_start, w_store;
    logic [DEPTH-1:0][7:0] r_rx_data;
    logic [CW-1:0]         r_rx_count;
    logic                  r_overflow, r_overrun, r_tx_req;

    spi_bit_engine #(.SYNC_FF(SYNC_FF)) u_eng (
        .i_clk       (i_sys_clk),
        .i_reset     (i_reset),
        .i_spi_sclk  (i_spi_sclk),
        .i_spi_cs_n  (i_spi_cs_n),
        .i_spi_rx    (i_spi_rx),
        .i_load      (w_load),
        .i_load_data (w_load_data),
        .o_spi_tx    (o_spi_tx),
        .o_byte_done (w_byte_done),
        .o_rx_byte   (w_rx_byte),
        .o_cs_rise   (w_cs_rise),
        .o_cs_fall   (w_cs_fall),
        .o_load_req  (w_load_req),
        .o_cs_n_s    (w_cs_n_s)
    );

    // An ack coinciding with a new cs fall releases the old frame and captures the new one.
    assign w_start = w_cs_fall && ((r_state == IDLE) || (r_state == PENDING && i_frame_ack));
    assign w_store = (r_state == ACTIVE) && w_byte_done && (r_rx_count < CW'(DEPTH));

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) r_state <= WAIT_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            WAIT_IDLE: if (w_cs_n_s)   w_next = IDLE;
            IDLE:      if (w_start)    w_next = ACTIVE;
            ACTIVE:    if (w_cs_rise)  w_next = (r_rx_count == '0) ? IDLE : PENDING;
            PENDING:   if (i_frame_ack) w_next = w_start ? ACTIVE : IDLE;
            default:   w_next = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            r_rx_data  <= '0;
            r_rx_count <= '0;
            r_overflow <= 1'b0;
            r_overrun  <= 1'b0;
            r_tx_req   <= 1'b0;
        end else begin
            r_tx_req <= (w_start && !STATUS_EN) || (r_state == ACTIVE && w_load_req);
            if (w_start) begin
                r_rx_count <= '0;
                r_overflow <= 1'b0;
            end else if (w_store) begin
                r_rx_count <= r_rx_count + 1'b1;
            end else if (r_state == ACTIVE && w_byte_done) begin
                r_overflow <= 1'b1;
            end
            for (int i = 0; i < DEPTH; i++)
                if (w_store && r_rx_count == CW'(i))
                    r_rx_data[i] <= w_rx_byte;
            if (r_state == PENDING && w_cs_fall && !i_frame_ack)
                r_overrun <= 1'b1;
        end
    end

`ifdef SPI_BUF_STATUS_EN
    logic          r_stat_load, r_ovf_prev;
    logic [CW-1:0] r_cnt_prev;

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            r_stat_load <= 1'b0;
            r_ovf_prev  <= 1'b0;
            r_cnt_prev  <= '0;
        end else begin
            r_stat_load <= w_start;
            if (r_state == ACTIVE && w_cs_rise) begin
                r_ovf_prev <= r_overflow;
                r_cnt_prev <= r_rx_count;
            end
        end
    end

    assign w_load      = r_tx_req | r_stat_load;
    assign w_load_data = r_stat_load ? status_byte(r_overrun, r_ovf_prev, 32'(r_cnt_prev))
                                     : i_tx_byte;
`else
    assign w_load      = r_tx_req;
    assign w_load_data = i_tx_byte;
`endif

    assign o_tx_req      = r_tx_req;
    assign o_rx_data     = r_rx_data;
    assign o_rx_count    = r_rx_count;
    assign o_frame_valid = (r_state == PENDING);
    assign o_overflow    = r_overflow;
    assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_spi_frame_buffer.sv
// Directed bench for spi_frame_buffer: frames, overflow, partial bytes, overrun, mid-frame reset.
module tb_spi_frame_buffer;

    localparam int DEPTH   = 4;
    localparam int SYNC_FF = 2;
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int HALF    = 8;

    logic              clk = 1'b0;
    logic              reset, sclk, cs_n, rx, tx, tx_req, frame_valid, ack, ovf, ovr;
    logic [7:0]        tx_byte;
    logic [DEPTH*8-1:0] rx_data;
    logic [CW-1:0]     rx_count;

    int checks = 0, failures = 0, txreq_cnt = 0;

`ifdef SPI_BUF_STATUS_EN
    localparam logic [7:0] EXP_B0_T1 = 8'h00;
    localparam logic [7:0] EXP_B0_T5 = 8'h81;
    localparam int         EXP_REQS  = 2;
`else
    localparam logic [7:0] EXP_B0_T1 = 8'hC3;
    localparam logic [7:0] EXP_B0_T5 = 8'hC3;
    localparam int         EXP_REQS  = 3;
`endif

    spi_frame_buffer #(.DEPTH(DEPTH), .SYNC_FF(SYNC_FF)) dut (
        .i_sys_clk     (clk),
        .i_reset       (reset),
        .i_spi_sclk    (sclk),
        .i_spi_cs_n    (cs_n),
        .i_spi_rx      (rx),
        .o_spi_tx      (tx),
        .i_tx_byte     (tx_byte),
        .o_tx_req      (tx_req),
        .o_rx_data     (rx_data),
        .o_rx_count    (rx_count),
        .o_frame_valid (frame_valid),
        .i_frame_ack   (ack),
        .o_overflow    (ovf),
        .o_overrun     (ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (tx_req) txreq_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] mosi, output logic [7:0] miso);
        for (int b = 7; b >= 0; b--) begin
            rx = mosi[b];
            repeat (HALF) @(negedge clk);
            miso[b] = tx;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    // Raises cs_n and returns the number of clock edges until frame_valid (0 = timed out).
    task automatic cs_high_valid(output int lat);
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (frame_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic cs_high_idle();
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        logic [7:0] m0, m1, dummy;
        int lat, req0;
        reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; rx = 1'b0; ack = 1'b0; tx_byte = 8'hC3;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(frame_valid), 32'd0);
        chk("rst_count", 32'(rx_count), 32'd0);
        chk("rst_data", rx_data, 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        chk("rst_txreq", 32'(tx_req), 32'd0);
        chk("rst_tx", 32'(tx), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // 1: two-byte frame
        req0 = txreq_cnt;
        cs_low();
        spi_byte(8'hA5, m0);
        spi_byte(8'h3C, m1);
        cs_high_valid(lat);
        chk("t1_latency", 32'(lat), 32'(SYNC_FF + 2));
        chk("t1_valid", 32'(frame_valid), 32'd1);
        chk("t1_count", 32'(rx_count), 32'd2);
        chk("t1_data", {16'h0, rx_data[15:0]}, 32'h3CA5);
        chk("t1_ovf", 32'(ovf), 32'd0);
        chk("t1_miso0", 32'(m0), 32'(EXP_B0_T1));
        chk("t1_miso1", 32'(m1), 32'hC3);
        chk("t1_txreqs", 32'(txreq_cnt - req0), 32'(EXP_REQS));
        do_ack();
        chk("t1_ack_valid", 32'(frame_valid), 32'd0);

        // 2: six bytes into a four-byte buffer
        cs_low();
        for (int i = 1; i <= 6; i++) spi_byte(8'(i), dummy);
        cs_high_valid(lat);
        chk("t2_valid", 32'(frame_valid), 32'd1);
        chk("t2_count", 32'(rx_count), 32'd4);
        chk("t2_data", rx_data, 32'h04030201);
        chk("t2_ovf", 32'(ovf), 32'd1);
        do_ack();

        // 3: partial byte only
        cs_low();
        for (int i = 0; i < 5; i++) begin
            rx = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        cs_high_idle();
        chk("t3_valid", 32'(frame_valid), 32'd0);
        chk("t3_count", 32'(rx_count), 32'd0);
        chk("t3_ovf", 32'(ovf), 32'd0);

        // 4: second frame while first is pending
        cs_low();
        spi_byte(8'h11, dummy);
        cs_high_valid(lat);
        chk("t4_valid1", 32'(frame_valid), 32'd1);
        cs_low();
        spi_byte(8'h22, m0);
        cs_high_idle();
        chk("t4_miso", 32'(m0), 32'h00);
        chk("t4_data", 32'(rx_data[7:0]), 32'h11);
        chk("t4_count", 32'(rx_count), 32'd1);
        chk("t4_overrun", 32'(ovr), 32'd1);
        chk("t4_valid2", 32'(frame_valid), 32'd1);
        do_ack();
        chk("t4_ack_valid", 32'(frame_valid), 32'd0);

        // 5: response stream
        cs_low();
        spi_byte(8'h99, m0);
        spi_byte(8'h66, m1);
        cs_high_valid(lat);
        chk("t5_miso0", 32'(m0), 32'(EXP_B0_T5));
        chk("t5_miso1", 32'(m1), 32'hC3);
        chk("t5_data", {16'h0, rx_data[15:0]}, 32'h6699);
        chk("t5_overrun", 32'(ovr), 32'd1);
        do_ack();

        // 6: reset in the middle of a frame
        cs_low();
        spi_byte(8'hAA, dummy);
        spi_byte(8'hBB, dummy);
        spi_byte(8'hCC, dummy);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        spi_byte(8'hDD, dummy);
        cs_high_idle();
        chk("t6_valid", 32'(frame_valid), 32'd0);
        chk("t6_count", 32'(rx_count), 32'd0);
        chk("t6_overrun", 32'(ovr), 32'd0);
        cs_low();
        spi_byte(8'h7E, dummy);
        cs_high_valid(lat);
        chk("t6_latency", 32'(lat), 32'(SYNC_FF + 2));
        chk("t6_count2", 32'(rx_count), 32'd1);
        chk("t6_data", 32'(rx_data[7:0]), 32'h7E);
        do_ack();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
